// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple adder; each bit is two half-adder cells joined by an OR.
module adder_chunk #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             msb_cin
);

   logic [CHUNK:0]   c;
   logic [CHUNK-1:0] p, g, h;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      assign p[i]   = a[i] ^ b[i];
      assign g[i]   = a[i] & b[i];
      assign sum[i] = p[i] ^ c[i];
      assign h[i]   = p[i] & c[i];
      assign c[i+1] = g[i] | h[i];
   end

   assign cout    = c[CHUNK];
   assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder processing CHUNK bits per clock, LSB chunk first.
// Optional signed-overflow output when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] KLAST = CW'(NCHUNK - 1);

   if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_q, b_q;
   logic             carry;
   logic [CW-1:0]    k;
   logic             last;
   logic [CHUNK-1:0] ca, cb, cs;
   logic             cc;

   assign last = (k == KLAST);
   assign ca   = a_q[int'(k)*CHUNK +: CHUNK];
   assign cb   = b_q[int'(k)*CHUNK +: CHUNK];

`ifdef SERIAL_ADDER_OVF_EN
   logic cm;
`else
   logic cm_unused;
`endif

   adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a       (ca),
      .b       (cb),
      .cin     (carry),
      .sum     (cs),
      .cout    (cc),
`ifdef SERIAL_ADDER_OVF_EN
      .msb_cin (cm)
`else
      .msb_cin (cm_unused)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign ready = (state == IDLE);
   assign busy  = (state == RUN);
   assign done  = (state == DONE);

   // k returns to 0 on the last chunk, so it never wraps past KLAST in RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         carry <= 1'b0;
         k     <= '0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               a_q   <= a;
               b_q   <= b;
               carry <= cin;
               k     <= '0;
               sum   <= '0;
            end
            RUN: begin
               sum[int'(k)*CHUNK +: CHUNK] <= cs;
               carry <= cc;
               if (last) begin
                  cout <= cc;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf  <= cc ^ cm;
`endif
                  k    <= '0;
               end else begin
                  k    <= k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Random + directed bench for serial_adder at CHUNK=2 and CHUNK=8 (WIDTH=8).
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst, start, cin;
   logic [7:0] a, b;

   logic       ready_o [2];
   logic       busy_o  [2];
   logic       done_o  [2];
   logic [7:0] sum_o   [2];
   logic       cout_o  [2];
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf_o   [2];
`endif

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .CHUNK(2)) dut0 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]),
      .sum(sum_o[0]), .cout(cout_o[0])
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf_o[0])
`endif
   );

   serial_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
      .ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]),
      .sum(sum_o[1]), .cout(cout_o[1])
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf_o[1])
`endif
   );

   // Reference model: m_cnt counts cycles left until back in idle.
   // NCHUNK+1 after acceptance, 1 means the done cycle, 0 means idle.
   int         nch [2] = '{4, 1};
   int         m_cnt [2] = '{0, 0};
   logic [7:0] m_pa [2], m_pb [2];
   logic       m_pc [2];
   logic [7:0] m_sum [2] = '{8'h00, 8'h00};
   logic       m_cout [2] = '{1'b0, 1'b0};
   logic       m_ovf [2] = '{1'b0, 1'b0};
   int         mu, ms;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_cnt[i] = 0; m_sum[i] = 8'h00; m_cout[i] = 1'b0; m_ovf[i] = 1'b0;
         end else if (m_cnt[i] == 0) begin
            if (start) begin
               m_pa[i] = a; m_pb[i] = b; m_pc[i] = cin;
               m_cnt[i] = nch[i] + 1;
            end
         end else begin
            m_cnt[i]--;
            if (m_cnt[i] == 1) begin
               mu = int'(m_pa[i]) + int'(m_pb[i]) + int'(m_pc[i]);
               ms = int'($signed(m_pa[i])) + int'($signed(m_pb[i])) + int'(m_pc[i]);
               m_sum[i]  = 8'(mu);
               m_cout[i] = (mu > 255);
               m_ovf[i]  = (ms > 127) || (ms < -128);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready%0d", i), 32'(ready_o[i]), 32'(m_cnt[i] == 0));
            chk($sformatf("busy%0d", i),  32'(busy_o[i]),  32'(m_cnt[i] > 1));
            chk($sformatf("done%0d", i),  32'(done_o[i]),  32'(m_cnt[i] == 1));
            if (m_cnt[i] <= 1) begin
               chk($sformatf("sum%0d", i),  32'(sum_o[i]),  32'(m_sum[i]));
               chk($sformatf("cout%0d", i), 32'(cout_o[i]), 32'(m_cout[i]));
`ifdef SERIAL_ADDER_OVF_EN
               chk($sformatf("ovf%0d", i),  32'(ovf_o[i]),  32'(m_ovf[i]));
`endif
            end
         end
      end
   end

   task automatic wait_idle();
      int g = 0;
      do begin
         @(posedge clk); #1;
         g++;
      end while ((m_cnt[0] != 0 || m_cnt[1] != 0) && g < 50);
      if (g >= 50) chk("idle_timeout", 32'(g), 32'(0));
   endtask

   // One operation on both DUTs, literal expectations at each done.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb2, input logic tc,
                        input logic [7:0] es, input logic ec, input logic eo);
      int lat [2];
      lat = '{0, 0};
      wait_idle();
      a = ta; b = tb2; cin = tc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      for (int n = 1; n <= 20 && (lat[0] == 0 || lat[1] == 0); n++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (done_o[i] && lat[i] == 0) begin
               lat[i] = n;
               chk($sformatf("op_sum%0d", i),  32'(sum_o[i]),  32'(es));
               chk($sformatf("op_cout%0d", i), 32'(cout_o[i]), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
               chk($sformatf("op_ovf%0d", i),  32'(ovf_o[i]),  32'(eo));
`endif
            end
         end
      end
      chk("lat_chunk2", 32'(lat[0]), 32'(5));
      chk("lat_chunk8", 32'(lat[1]), 32'(2));
   endtask

   initial begin
      int nd;
      rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(ready_o[0]), 32'(1));
      chk("rst_busy",  32'(busy_o[0]),  32'(0));
      chk("rst_done",  32'(done_o[0]),  32'(0));
      chk("rst_sum",   32'(sum_o[0]),   32'(0));
      chk("rst_cout",  32'(cout_o[0]),  32'(0));

      do_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      repeat (5) @(negedge clk);
      chk("hold_sum",  32'(sum_o[0]),  32'(8'hFF));
      chk("hold_cout", 32'(cout_o[0]), 32'(1));

      // start during RUN must be ignored
      wait_idle();
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; a = 8'hAA;
      @(posedge clk); #1;
      start = 1'b0;
      nd = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (done_o[0]) begin
            nd++;
            chk("ign_sum", 32'(sum_o[0]), 32'(8'h30));
         end
      end
      chk("ign_done_cnt", 32'(nd), 32'(1));

      // reset in the third RUN cycle abandons the operation
      wait_idle();
      a = 8'h55; b = 8'h66; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mrst_ready", 32'(ready_o[0]), 32'(1));
      chk("mrst_busy",  32'(busy_o[0]),  32'(0));
      chk("mrst_sum",   32'(sum_o[0]),   32'(0));
      chk("mrst_cout",  32'(cout_o[0]),  32'(0));
      nd = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (done_o[0]) nd++;
      end
      chk("mrst_no_done", 32'(nd), 32'(0));
      do_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

      // randomized traffic, checked every cycle against the model
      for (int n = 0; n < 600; n++) begin
         @(posedge clk); #1;
         rst   = ($urandom_range(0, 49) == 0);
         start = ($urandom_range(0, 2) == 0);
         a     = 8'($urandom);
         b     = 8'($urandom);
         cin   = 1'($urandom);
      end
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and sum width in bits; minimum 2.
REQ-002 SHALL have parameter CHUNK, default 2: bits added per clock; WIDTH SHALL be an integer multiple of CHUNK; elaboration SHALL error otherwise.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin an addition; sampled only when ready=1.
REQ-006 SHALL have port a  input  WIDTH  operand A; captured on the accepted start.
REQ-007 SHALL have port b  input  WIDTH  operand B; captured on the accepted start.
REQ-008 SHALL have port cin  input  1  carry-in; captured on the accepted start.
REQ-009 SHALL have port ready  output  1  high only in IDLE; an accepted start needs start=1 and ready=1.
REQ-010 SHALL have port busy  output  1  high only in RUN.
REQ-011 SHALL have port done  output  1  single-cycle pulse; result valid.
REQ-012 SHALL have port sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE: on an accepted start, SHALL capture a, b and cin, clear the chunk counter and the sum register, and move to RUN; otherwise SHALL stay in IDLE.
REQ-016 RUN: each cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK) of both operands plus the running carry, write the chunk into sum, update the running carry, and increment k.
REQ-017 RUN: on the cycle that processes chunk NCHUNK-1 (NCHUNK = WIDTH/CHUNK), SHALL register cout and move to DONE.
REQ-018 DONE: SHALL assert done for exactly one cycle, then move to IDLE unconditionally.
REQ-019 Latency: done SHALL be high in the cycle that begins NCHUNK+1 rising edges after the accepting edge.
REQ-020 sum and cout SHALL hold their values from done until the next accepted start; during RUN they are not valid.
REQ-021 start SHALL be ignored in RUN and DONE; the operation in flight SHALL be unaffected.
REQ-022 Changes on a, b or cin after acceptance SHALL NOT affect the result.
REQ-023 CHUNK=WIDTH SHALL give NCHUNK=1, meaning one RUN cycle and done on the second edge after acceptance.
REQ-024 The chunk counter SHALL be ceil(log2(NCHUNK)) bits wide, with a minimum of 1, and SHALL never wrap while in RUN.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, ready=1, busy=0, done=0, sum=0, cout=0, counter=0 and carry=0, overriding start in the same cycle.
REQ-026 Reset during RUN or DONE SHALL abandon the operation, with no done pulse.

Configuration
REQ-027 With SERIAL_ADDER_OVF_EN defined: SHALL add port ovf  output  1  signed two's-complement overflow, registered with cout; ovf=1 when the carry into the MSB differs from the carry out of it; ovf resets to 0 and holds like sum.
REQ-028 Without SERIAL_ADDER_OVF_EN: no ovf port and no overflow logic.

Structure
REQ-029 Package serial_adder_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and a function computing NCHUNK.
REQ-030 Sub-module adder_chunk (combinational, CHUNK-bit ripple adder built from half-adder cells, with carry-in, sum, carry-out and MSB carry-in for ovf) SHALL be instantiated once.

Verification (WIDTH=8, CHUNK=2 unless noted)
REQ-031 a=0x3C, b=0x05, cin=0, start pulse -> ready drops; busy for 4 cycles; done on the 5th edge; sum=0x41, cout=0.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with the macro, ovf=0. Then a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
REQ-033 a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; sum and cout stay held after done until the next start.
REQ-034 Start 0x10+0x20, then start=1 with a=0xAA in the 2nd RUN cycle -> ignored; single done, sum=0x30.
REQ-035 rst=1 in the 3rd RUN cycle -> next cycle IDLE, sum=0, cout=0, ready=1, no done pulse; a following 0x01+0x01 -> sum=0x02.
REQ-036 WIDTH=8, CHUNK=8: 0x80+0x80 -> done on the 2nd edge after acceptance, sum=0x00, cout=1.
